// File: rtl/ir_gate_pkg.sv
// Shared types and default constants for the two-beam doorway occupancy counter.
package ir_gate_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInA,
    StInAb,
    StInB,
    StOutB,
    StOutAb,
    StOutA,
    StClear
  } gate_state_e;

  localparam int unsigned DefCntW       = 8;
  localparam int unsigned DefMaxCount   = 99;
  localparam int unsigned DefTimeoutCyc = 200_000_000;
  localparam int unsigned DefTmoW       = 28;

  // True for states that belong to an in-flight passage.
  function automatic logic is_passage(gate_state_e s);
    return (s != StIdle) && (s != StClear);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter saturating at 0 and MAX_COUNT; clr has priority. full/empty registered.
module sat_updown_counter #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_COUNT = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != MaxCnt) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == MaxCnt);
      empty_q <= (count_d == '0);
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ir_gate_counter.sv
// Two-beam doorway passage tracker with saturating occupancy count and event pulses.
// Optional stall timeout compiled in with IR_GATE_TIMEOUT_EN.
module ir_gate_counter
  import ir_gate_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned MAX_COUNT   = DefMaxCount,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  parameter int unsigned TMO_W       = DefTmoW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_a,
  input  logic             det_b,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             entry_pulse,
  output logic             exit_pulse,
  output logic             abort_pulse,
  output logic             busy
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYC - 1);

  gate_state_e state_q, state_d;
  logic        entry_d, exit_d, abort_d;
  logic        entry_q, exit_q, abort_q, busy_q;
  logic        tmo_hit;
  logic [1:0]  ab;

  assign ab = {det_a, det_b};

`ifdef IR_GATE_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = is_passage(state_q) && (tmo_q == TmoLast);

  // Counts cycles spent in the current passage state; restarts on every transition.
  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (!is_passage(state_q) || (state_d != state_q)) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TmoLast;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        case (ab)
          2'b10:   state_d = StInA;
          2'b01:   state_d = StOutB;
          2'b11:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StInA: begin
        case (ab)
          2'b11:   state_d = StInAb;
          2'b00:   state_d = StIdle;
          2'b01:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StInAb: begin
        case (ab)
          2'b01:   state_d = StInB;
          2'b10:   state_d = StInA;
          2'b00:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StInB: begin
        case (ab)
          2'b00:   begin state_d = StIdle; entry_d = 1'b1; end
          2'b11:   state_d = StInAb;
          2'b10:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StOutB: begin
        case (ab)
          2'b11:   state_d = StOutAb;
          2'b00:   state_d = StIdle;
          2'b10:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StOutAb: begin
        case (ab)
          2'b10:   state_d = StOutA;
          2'b01:   state_d = StOutB;
          2'b00:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StOutA: begin
        case (ab)
          2'b00:   begin state_d = StIdle; exit_d = 1'b1; end
          2'b11:   state_d = StOutAb;
          2'b01:   begin state_d = StClear; abort_d = 1'b1; end
          default: ;
        endcase
      end
      StClear: begin
        if (ab == 2'b00) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A stalled passage is discarded even if the inputs would have moved it on.
    if (tmo_hit) begin
      state_d = StClear;
      entry_d = 1'b0;
      exit_d  = 1'b0;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  sat_updown_counter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (MAX_COUNT)
  ) u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (entry_d),
    .dec   (exit_d),
    .clr   (clr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign entry_pulse = entry_q;
  assign exit_pulse  = exit_q;
  assign abort_pulse = abort_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ir_gate_counter.sv
// Directed self-checking bench for ir_gate_counter; timeout scenario follows IR_GATE_TIMEOUT_EN.
module tb_ir_gate_counter;

  localparam int unsigned CntW    = 8;
  localparam int unsigned MaxCnt  = 99;
  localparam int unsigned TmoCyc  = 50;
  localparam int unsigned TmoW    = 28;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            det_a = 1'b0;
  logic            det_b = 1'b0;
  logic            clr = 1'b0;
  logic [CntW-1:0] count;
  logic            full, empty, entry_pulse, exit_pulse, abort_pulse, busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_entry = 0;
  int n_exit = 0;
  int n_abort = 0;
  int n_multi = 0;

  always #5 clk = ~clk;

  ir_gate_counter #(
    .CNT_W       (CntW),
    .MAX_COUNT   (MaxCnt),
    .TIMEOUT_CYC (TmoCyc),
    .TMO_W       (TmoW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .det_a       (det_a),
    .det_b       (det_b),
    .clr         (clr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .abort_pulse (abort_pulse),
    .busy        (busy)
  );

  // Apply (a,b) for n cycles, sampling 1 time unit after each rising edge.
  task automatic drive(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      det_a = a;
      det_b = b;
      @(posedge clk);
      #1;
      if (entry_pulse) n_entry++;
      if (exit_pulse)  n_exit++;
      if (abort_pulse) n_abort++;
      if (int'(entry_pulse) + int'(exit_pulse) + int'(abort_pulse) > 1) n_multi++;
    end
  endtask

  task automatic clear_tallies();
    n_entry = 0;
    n_exit  = 0;
    n_abort = 0;
  endtask

  task automatic do_entry(input int n);
    drive(1'b1, 1'b0, n);
    drive(1'b1, 1'b1, n);
    drive(1'b0, 1'b1, n);
    drive(1'b0, 1'b0, n);
  endtask

  task automatic do_exit(input int n);
    drive(1'b0, 1'b1, n);
    drive(1'b1, 1'b1, n);
    drive(1'b1, 1'b0, n);
    drive(1'b0, 1'b0, n);
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({count, full, empty, entry_pulse, exit_pulse, abort_pulse, busy} !== {8'd0, 6'b010000}) begin
      n_err++;
      $display("FAIL reset_state: got count=%0d full=%b empty=%b pulses=%b%b%b busy=%b, want 0 0 1 000 0",
               count, full, empty, entry_pulse, exit_pulse, abort_pulse, busy);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2);
    n_cmp++;
    if ({busy, empty, count} !== {2'b01, 8'd0}) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b empty=%b count=%0d, want 0 1 0", busy, empty, count);
    end
  endtask

  task automatic test_entry();
    clear_tallies();
    drive(1'b1, 1'b0, 10);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL entry_busy: got %b want 1", busy);
    end
    drive(1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if ({entry_pulse, count, empty, busy} !== {1'b1, 8'd1, 2'b00}) begin
      n_err++;
      $display("FAIL entry_commit: got pulse=%b count=%0d empty=%b busy=%b, want 1 1 0 0",
               entry_pulse, count, empty, busy);
    end
    drive(1'b0, 1'b0, 9);
    n_cmp++;
    if ({n_entry, n_exit, n_abort} !== {32'd1, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL entry_pulses: got entry=%0d exit=%0d abort=%0d, want 1 0 0", n_entry, n_exit, n_abort);
    end
  endtask

  task automatic test_exit();
    do_entry(1);
    do_entry(1);
    n_cmp++;
    if (count !== 8'd3) begin
      n_err++;
      $display("FAIL min_passage_count: got %0d want 3", count);
    end
    clear_tallies();
    do_exit(10);
    n_cmp++;
    if ({count, n_exit, n_entry} !== {8'd2, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL exit_basic: got count=%0d exit=%0d entry=%0d, want 2 1 0", count, n_exit, n_entry);
    end
    do_exit(2);
    do_exit(2);
    clear_tallies();
    do_exit(2);
    n_cmp++;
    if ({count, empty, n_exit} !== {8'd0, 1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL exit_at_zero: got count=%0d empty=%b exit=%0d, want 0 1 1", count, empty, n_exit);
    end
  endtask

  task automatic test_reversal();
    do_entry(1);
    clear_tallies();
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b1, 3);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 3);
    n_cmp++;
    if ({n_entry, n_exit, n_abort, count, busy} !== {32'd0, 32'd0, 32'd0, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL reversal: got entry=%0d exit=%0d abort=%0d count=%0d busy=%b, want 0 0 0 1 0",
               n_entry, n_exit, n_abort, count, busy);
    end
  endtask

  task automatic test_saturation();
    det_a = 1'b0;
    det_b = 1'b0;
    clr = 1'b1;
    drive(1'b0, 1'b0, 1);
    clr = 1'b0;
    n_cmp++;
    if ({count, empty} !== {8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL clr_level: got count=%0d empty=%b, want 0 1", count, empty);
    end
    clear_tallies();
    for (int i = 0; i < 99; i++) do_entry(1);
    n_cmp++;
    if ({count, full, empty} !== {8'd99, 2'b10}) begin
      n_err++;
      $display("FAIL reach_max: got count=%0d full=%b empty=%b, want 99 1 0", count, full, empty);
    end
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if ({entry_pulse, count, full} !== {1'b1, 8'd99, 1'b1}) begin
      n_err++;
      $display("FAIL saturate_hold: got pulse=%b count=%0d full=%b, want 1 99 1", entry_pulse, count, full);
    end
    n_cmp++;
    if (n_entry !== 100) begin
      n_err++;
      $display("FAIL saturate_pulses: got %0d want 100", n_entry);
    end
    do_exit(1);
    n_cmp++;
    if ({count, full} !== {8'd98, 1'b0}) begin
      n_err++;
      $display("FAIL exit_from_full: got count=%0d full=%b, want 98 0", count, full);
    end
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1);
    clr = 1'b1;
    drive(1'b0, 1'b0, 1);
    clr = 1'b0;
    n_cmp++;
    if ({entry_pulse, count, empty, full} !== {1'b1, 8'd0, 2'b10}) begin
      n_err++;
      $display("FAIL clr_vs_commit: got pulse=%b count=%0d empty=%b full=%b, want 1 0 1 0",
               entry_pulse, count, empty, full);
    end
  endtask

  task automatic test_anomaly();
    clear_tallies();
    drive(1'b1, 1'b1, 1);
    n_cmp++;
    if ({abort_pulse, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL idle_both_abort: got abort=%b busy=%b, want 1 1", abort_pulse, busy);
    end
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b0, 3);
    n_cmp++;
    if ({busy, n_abort} !== {1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL clear_wait: got busy=%b aborts=%0d, want 1 1", busy, n_abort);
    end
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_release: got busy=%b want 0", busy);
    end
    clear_tallies();
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 1);
    n_cmp++;
    if ({abort_pulse, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL in_a_violation: got abort=%b busy=%b, want 1 1", abort_pulse, busy);
    end
    drive(1'b0, 1'b0, 2);
    clear_tallies();
    drive(1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if ({abort_pulse, n_exit, count} !== {1'b1, 32'd0, 8'd0}) begin
      n_err++;
      $display("FAIL out_ab_violation: got abort=%b exits=%0d count=%0d, want 1 0 0",
               abort_pulse, n_exit, count);
    end
    drive(1'b0, 1'b0, 2);
  endtask

  task automatic test_timeout();
    int first_abort;
    first_abort = 0;
    clear_tallies();
    for (int i = 1; i <= 60; i++) begin
      drive(1'b1, 1'b0, 1);
      if (abort_pulse && first_abort == 0) first_abort = i;
    end
`ifdef IR_GATE_TIMEOUT_EN
    // IN_A entered at sample 1; abort lands TmoCyc edges later.
    n_cmp++;
    if (first_abort !== int'(TmoCyc) + 1) begin
      n_err++;
      $display("FAIL timeout_latency: got sample %0d want %0d", first_abort, TmoCyc + 1);
    end
    n_cmp++;
    if ({n_abort, busy} !== {32'd1, 1'b1}) begin
      n_err++;
      $display("FAIL timeout_clear: got aborts=%0d busy=%b, want 1 1", n_abort, busy);
    end
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if ({busy, n_entry} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL timeout_release: got busy=%b entries=%0d, want 0 0", busy, n_entry);
    end
`else
    n_cmp++;
    if ({first_abort, busy} !== {32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL no_timeout: got first_abort=%0d busy=%b, want 0 1", first_abort, busy);
    end
    drive(1'b0, 1'b0, 1);
    n_cmp++;
    if ({busy, n_abort, n_entry} !== {1'b0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL no_timeout_backout: got busy=%b aborts=%0d entries=%0d, want 0 0 0",
               busy, n_abort, n_entry);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_entry(1);
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, full, empty, entry_pulse, exit_pulse, abort_pulse, busy} !== {8'd0, 6'b010000}) begin
      n_err++;
      $display("FAIL reset_mid: got count=%0d full=%b empty=%b pulses=%b%b%b busy=%b, want 0 0 1 000 0",
               count, full, empty, entry_pulse, exit_pulse, abort_pulse, busy);
    end
    det_a = 1'b0;
    det_b = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear_tallies();
    drive(1'b0, 1'b0, 3);
    n_cmp++;
    if ({busy, n_entry, n_exit, n_abort, count} !== {1'b0, 96'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b e=%0d x=%0d a=%0d count=%0d, want 0 0 0 0 0",
               busy, n_entry, n_exit, n_abort, count);
    end
    drive(1'b1, 1'b0, 1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_reenter: got busy=%b want 1", busy);
    end
    drive(1'b0, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_reversal();
    test_saturation();
    test_anomaly();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (n_multi !== 0) begin
      n_err++;
      $display("FAIL pulse_exclusive: got %0d overlapping samples want 0", n_multi);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
